// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_stage
//  Purpose  : Generic pipeline stage register with valid/ready handshake,
//             optional 2-entry skid buffer, hold-level stall and flush.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int              DW         = 32,
    parameter logic [DW-1:0]   NOP_VAL    = {DW{1'b0}},
    parameter int              HOLD_W     = 3,
    parameter int              HOLD_LEVEL = 2,
    parameter int              SKID       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DW-1:0]     in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DW-1:0]     out_data_o,
    output logic [1:0]        occupancy_o
);

    // Occupancy encoding: number of beats currently held.
    localparam logic [1:0]        C_EMPTY      = 2'd0;
    localparam logic [1:0]        C_ONE        = 2'd1;
    localparam logic [1:0]        C_TWO        = 2'd2;
    localparam logic [HOLD_W-1:0] C_HOLD_LEVEL = HOLD_W'(HOLD_LEVEL);

    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] m_q, m_d;      // head beat, always the one presented downstream
    logic [DW-1:0] s_q, s_d;      // second beat, only used with the skid buffer

    logic w_stall;
    logic w_ready_base;           // ready before stall/reset qualification
    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;

    assign w_stall = (hold_flag_i >= C_HOLD_LEVEL) & ~rst;

    // Ready policy: the skid variant decouples ready from out_ready_i so the
    // upstream timing path stops at this stage; the single-entry variant
    // forwards downstream readiness combinationally to keep full throughput.
    generate
        if (SKID != 0) begin : g_skid
            assign w_ready_base = (occ_q != C_TWO);
        end else begin : g_single
            assign w_ready_base = (occ_q == C_EMPTY) | out_ready_i;
        end
    endgenerate

    // Handshake outputs and fire qualifiers derived from the held state.
    always_comb begin
        w_out_valid = (occ_q != C_EMPTY) & ~w_stall & ~rst;
        w_in_ready  = w_ready_base & ~w_stall & ~rst;
        w_in_fire   = in_valid_i & w_in_ready & ~w_stall & ~flush_i;
        w_out_fire  = w_out_valid & out_ready_i;
    end

    // State register: reset clears all held beats to the bubble value.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= C_EMPTY;
            m_q   <= NOP_VAL;
            s_q   <= NOP_VAL;
        end else begin
            occ_q <= occ_d;
            m_q   <= m_d;
            s_q   <= s_d;
        end
    end

    // Next-state logic: flush dominates; otherwise advance the 0/1/2 queue.
    // A stall needs no explicit branch because both fires are already masked.
    always_comb begin
        occ_d = occ_q;
        m_d   = m_q;
        s_d   = s_q;
        if (flush_i) begin
            occ_d = C_EMPTY;
            m_d   = NOP_VAL;
            s_d   = NOP_VAL;
        end else begin
            case (occ_q)
                C_EMPTY: begin
                    if (w_in_fire) begin
                        occ_d = C_ONE;
                        m_d   = in_data_i;
                    end
                end
                C_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        m_d = in_data_i;
                    end else if (w_in_fire && (SKID != 0)) begin
                        occ_d = C_TWO;
                        s_d   = in_data_i;
                    end else if (w_out_fire) begin
                        occ_d = C_EMPTY;
                    end
                end
                C_TWO: begin
                    // Ready is low here, so only a drain can happen.
                    if (w_out_fire) begin
                        occ_d = C_ONE;
                        m_d   = s_q;
                    end
                end
                default: begin
                    occ_d = C_EMPTY;
                end
            endcase
        end
    end

    // Output drive: bubbles carry NOP_VAL so downstream decode sees a no-op.
    always_comb begin
        in_ready_o  = w_in_ready;
        out_valid_o = w_out_valid;
        out_data_o  = w_out_valid ? m_q : NOP_VAL;
        occupancy_o = occ_q;
    end

endmodule
`default_nettype wire
